data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 64-bit data memory behind a valid/ready
// request/response handshake. Out-of-range word addresses return an error
// and bump a saturating error counter.
// Optional feature macro DMEM_WAIT_EN: when defined, each access is delayed
// by WAIT_CYCLES wait states (latency WAIT_CYCLES+1); otherwise latency is 1.

module data_mem_responder #(
   parameter int unsigned DEPTH       = 201,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [7:0]  err_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Wait-state load value must fit the 4-bit counter and be non-zero.
   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("WAIT_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      StIdle,
`ifdef DMEM_WAIT_EN
      StWait,
`endif
      StResp
   } state_e;

   state_e state_q, state_d;

   // Memory starts all-zero; reset deliberately leaves contents untouched.
   logic [63:0] mem [DEPTH] = '{default: 64'd0};

   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  err_count_q, err_count_d;

   // Access operands: the live request when there are no wait states,
   // otherwise the copy captured at acceptance.
   logic          acc_en;
   logic          acc_write;
   logic [63:0]   acc_addr;
   logic [63:0]   acc_wdata;
   logic          acc_in_range;
   logic [AW-1:0] acc_idx;
   logic          mem_we;

`ifdef DMEM_WAIT_EN
   logic        lat_write_q;
   logic [63:0] lat_addr_q;
   logic [63:0] lat_wdata_q;
   logic [3:0]  cnt_q, cnt_d;

   assign acc_write = lat_write_q;
   assign acc_addr  = lat_addr_q;
   assign acc_wdata = lat_wdata_q;
`else
   assign acc_write = req_write;
   assign acc_addr  = req_addr;
   assign acc_wdata = req_wdata;
`endif

   // Full 64-bit compare so large addresses never alias into the array.
   assign acc_in_range = (acc_addr < 64'(DEPTH));
   assign acc_idx      = acc_addr[AW-1:0];
   assign mem_we       = acc_en & acc_write & acc_in_range;

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign err_count  = err_count_q;

   // Next-state, access strobe and response/error-counter updates.
   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      err_count_d = err_count_q;
      acc_en      = 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
`ifdef DMEM_WAIT_EN
               state_d = StWait;
               cnt_d   = 4'(WAIT_CYCLES);
`else
               state_d = StResp;
               acc_en  = 1'b1;
`endif
            end
         end
`ifdef DMEM_WAIT_EN
         StWait: begin
            if (cnt_q <= 4'd1) begin
               acc_en  = 1'b1;
               state_d = StResp;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (acc_en) begin
         if (!acc_in_range) begin
            rdata_d = 64'd0;
            err_d   = 1'b1;
            if (err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
         end else begin
            err_d   = 1'b0;
            rdata_d = acc_write ? 64'd0 : mem[acc_idx];
         end
      end
   end

   // Control and response registers; reset wins over any same-edge access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rdata_q     <= 64'd0;
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
`ifdef DMEM_WAIT_EN
         cnt_q       <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
`ifdef DMEM_WAIT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

`ifdef DMEM_WAIT_EN
   // Capture the request at acceptance; later req_* activity is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_write_q <= 1'b0;
         lat_addr_q  <= 64'd0;
         lat_wdata_q <= 64'd0;
      end else if (state_q == StIdle && req_valid) begin
         lat_write_q <= req_write;
         lat_addr_q  <= req_addr;
         lat_wdata_q <= req_wdata;
      end
   end
`endif

   // Memory write port; suppressed by reset so an aborted access never lands.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a behavioural memory model.
module tb_data_mem_responder;

   localparam int DEPTH = 201;
`ifdef DMEM_WAIT_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  err_count;

   int total = 0;
   int bad   = 0;

   logic [63:0] m_mem [DEPTH];
   int          m_ec;

   data_mem_responder #(
      .DEPTH      (DEPTH),
      .WAIT_CYCLES(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: out-of-range -> error, no write, rdata 0; write -> rdata 0.
   function automatic void model_access(input bit wr, input logic [63:0] addr,
                                        input logic [63:0] wdata,
                                        output logic [63:0] exp_rdata,
                                        output logic exp_err);
      if (addr >= 64'(DEPTH)) begin
         exp_err   = 1'b1;
         exp_rdata = 64'd0;
         if (m_ec < 255) m_ec++;
      end else begin
         exp_err = 1'b0;
         if (wr) begin
            m_mem[int'(addr)] = wdata;
            exp_rdata = 64'd0;
         end else begin
            exp_rdata = m_mem[int'(addr)];
         end
      end
   endfunction

   // Drives one transaction, holds resp_ready low for 'hold' cycles, reports observations.
   task automatic run_req(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input int hold, output int lat, output logic [63:0] rdata,
                          output logic err, output logic [7:0] ec, output bit stable,
                          output bit idle_after, output bit rdy_ok);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      rdy_ok    = (req_ready === 1'b1);
      @(posedge clk);
      #1;
      // Junk in-range writes while busy; they must be ignored.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'($urandom_range(0, DEPTH - 1));
      req_wdata = {$urandom, $urandom};
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 40) begin
         if (req_ready !== 1'b0) rdy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      rdata  = resp_rdata;
      err    = resp_err;
      ec     = err_count;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
             req_ready !== 1'b0) stable = 1'b0;
      end
      if (req_ready !== 1'b0) rdy_ok = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      idle_after = (resp_valid === 1'b0 && req_ready === 1'b1 &&
                    resp_rdata === rdata && resp_err === err);
   endtask

   task automatic test_reset();
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      rst        = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
      m_ec = 0;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_req_ready got=%b want=1", req_ready);
      end
      total++;
      if (resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_resp_valid got=%b want=0", resp_valid);
      end
      total++;
      if (resp_rdata !== 64'd0) begin
         bad++;
         $display("FAIL reset_resp_rdata got=%0h want=0", resp_rdata);
      end
      total++;
      if (resp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_resp_err got=%b want=0", resp_err);
      end
      total++;
      if (err_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_err_count got=%0d want=0", err_count);
      end
   endtask

   // Runs a transaction against the model and checks every observation inline.
   task automatic test_access(input string name, input bit wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input int hold);
      int          lat;
      logic [63:0] rdata, exp_rdata;
      logic        err, exp_err;
      logic [7:0]  ec;
      bit          stable, idle_after, rdy_ok;
      run_req(wr, addr, wdata, hold, lat, rdata, err, ec, stable, idle_after, rdy_ok);
      model_access(wr, addr, wdata, exp_rdata, exp_err);
      total++;
      if (lat !== LAT) begin
         bad++;
         $display("FAIL %s latency got=%0d want=%0d", name, lat, LAT);
      end
      total++;
      if (rdata !== exp_rdata) begin
         bad++;
         $display("FAIL %s rdata addr=%0h got=%0h want=%0h", name, addr, rdata, exp_rdata);
      end
      total++;
      if (err !== exp_err) begin
         bad++;
         $display("FAIL %s err addr=%0h got=%b want=%b", name, addr, err, exp_err);
      end
      total++;
      if (ec !== 8'(m_ec)) begin
         bad++;
         $display("FAIL %s err_count got=%0d want=%0d", name, ec, m_ec);
      end
      total++;
      if (!(stable && rdy_ok && idle_after)) begin
         bad++;
         $display("FAIL %s handshake stable=%b ready=%b idle_after=%b want 1 1 1",
                  name, stable, rdy_ok, idle_after);
      end
   endtask

   task automatic test_write_read();
      test_access("wr_addr5", 1'b1, 64'd5, 64'h1234, 0);
      test_access("rd_addr5", 1'b0, 64'd5, 64'd0, 0);
      test_access("rd_unwritten", 1'b0, 64'd200, 64'd0, 0);
   endtask

   task automatic test_out_of_range();
      test_access("wr_addr201", 1'b1, 64'd201, 64'hDEAD, 0);
      test_access("rd_addr201", 1'b0, 64'd201, 64'd0, 0);
      test_access("wr_alias_hi", 1'b1, 64'h1_0000_0005, 64'hBEEF, 0);
      test_access("rd_addr5_again", 1'b0, 64'd5, 64'd0, 0);
      test_access("wr_addr200", 1'b1, 64'd200, 64'h55AA, 0);
      test_access("rd_addr200", 1'b0, 64'd200, 64'd0, 0);
   endtask

   task automatic test_backpressure();
      test_access("bp_write", 1'b1, 64'd12, 64'hCAFE_F00D, 5);
      test_access("bp_read", 1'b0, 64'd12, 64'd0, 5);
   endtask

   task automatic test_reset_mid();
      // Reset in the busy state drops the pending access/response.
      @(negedge clk);
`ifdef DMEM_WAIT_EN
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'd7;
      req_wdata = 64'hFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
`else
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 64'd7;
      req_wdata = 64'd0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`endif
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      m_ec = 0;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset state got valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b0 || err_count !== 8'd0) begin
         bad++;
         $display("FAIL mid_reset after got valid=%b ec=%0d want 0 0", resp_valid, err_count);
      end
      test_access("rd_addr7", 1'b0, 64'd7, 64'd0, 0);

      // Reset coincident with a request: no acceptance, no write.
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'd9;
      req_wdata = 64'hAB;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_vs_accept got valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      test_access("rd_addr9", 1'b0, 64'd9, 64'd0, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [63:0] addr;
         int          r;
         r = int'($urandom_range(0, 9));
         if (r < 6)       addr = 64'($urandom_range(0, 15));
         else if (r < 8)  addr = 64'($urandom_range(DEPTH - 2, DEPTH + 1));
         else             addr = {$urandom, $urandom} | 64'h1_0000_0000;
         test_access("random", 1'($urandom), addr, {$urandom, $urandom},
                     int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 260; n++) begin
         int          lat;
         logic [63:0] rdata, exp_rdata;
         logic        err, exp_err;
         logic [7:0]  ec;
         bit          stable, idle_after, rdy_ok;
         run_req(1'($urandom), 64'(DEPTH) + 64'($urandom_range(0, 1000)), 64'd1, 0,
                 lat, rdata, err, ec, stable, idle_after, rdy_ok);
         model_access(1'b0, 64'(DEPTH), 64'd0, exp_rdata, exp_err);
         if (n == 259) begin
            total++;
            if (ec !== 8'd255) begin
               bad++;
               $display("FAIL saturation err_count got=%0d want=255", ec);
            end
            total++;
            if (err !== 1'b1 || rdata !== 64'd0) begin
               bad++;
               $display("FAIL saturation resp got err=%b rdata=%0h want 1 0", err, rdata);
            end
         end
      end
      total++;
      if (err_count !== 8'd255) begin
         bad++;
         $display("FAIL saturation hold got=%0d want=255", err_count);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
      m_ec = 0;
      test_reset();
      test_write_read();
      test_out_of_range();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
